// File: rtl/dmux_pkg.sv
// Shared definitions for the 1-to-4 dispatch demux and its 4:1 operand-mux counterpart.
package dmux_pkg;

   localparam int WIDTH_DEFAULT = 16;
   localparam int NUM_DEST      = 4;

   typedef logic [1:0] sel_t;

   // Destination encodings, shared with the operand-mux select logic.
   localparam sel_t SEL_OUT1 = 2'b00;
   localparam sel_t SEL_OUT2 = 2'b01;
   localparam sel_t SEL_OUT3 = 2'b10;
   localparam sel_t SEL_OUT4 = 2'b11;

   // One-hot destination decode of a select value.
   function automatic logic [NUM_DEST-1:0] sel_decode(input sel_t sel);
      logic [NUM_DEST-1:0] onehot;
      onehot = '0;
      case (sel)
         SEL_OUT1: onehot = 4'b0001;
         SEL_OUT2: onehot = 4'b0010;
         SEL_OUT3: onehot = 4'b0100;
         SEL_OUT4: onehot = 4'b1000;
         default:  onehot = '0;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry holding buffer for a single destination: data register plus full flag.
// A fill in the same cycle as a drain reloads the slot with no bubble; the
// data register is never cleared by a drain, only overwritten by the next fill.
module dmux_slot
   import dmux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill,
   input  logic [WIDTH-1:0] fill_data,
   input  logic             take,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   logic drain;

   // A take request only counts while the slot actually holds a word.
   assign drain = full & take;

   // Slot state: fill has priority over drain so a same-cycle refill keeps full set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data <= '0;
         full <= 1'b0;
      end else begin
         if (fill) begin
            data <= fill_data;
            full <= 1'b1;
         end else if (drain) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dmux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: dispatches one producer word to one of four
// consumers, each behind its own one-entry slot with valid/ready handshake.
// Only the addressed slot can back-pressure the producer.
module dmux_1to4_reg
   import dmux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [CNT_W-1:0] xfer_cnt
);

   sel_t                sel;
   logic [NUM_DEST-1:0] sel_onehot;
   logic [NUM_DEST-1:0] full;
   logic [NUM_DEST-1:0] fill_vec;
   logic                accept;
   logic [WIDTH-1:0]    slot_data [NUM_DEST];

   assign sel        = sel_t'(in_sel);
   assign sel_onehot = sel_decode(sel);

   // The addressed slot can take a word if it is empty or being drained this cycle.
   assign in_ready = ~full[sel] | out_ready[sel];
   assign accept   = in_valid & in_ready;

   // Steer the accept strobe to the addressed slot only.
   always_comb begin
      fill_vec = '0;
      if (accept) begin
         fill_vec = sel_onehot;
      end
   end

   for (genvar i = 0; i < NUM_DEST; i++) begin : g_slot
      dmux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .fill      (fill_vec[i]),
         .fill_data (in_data),
         .take      (out_ready[i]),
         .data      (slot_data[i]),
         .full      (full[i])
      );
   end

   assign out_valid = full;
   assign out1      = slot_data[0];
   assign out2      = slot_data[1];
   assign out3      = slot_data[2];
   assign out4      = slot_data[3];

   // Accepted-word counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (accept) begin
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmux_1to4_reg.sv
// Self-checking bench for dmux_1to4_reg: directed scenarios with literal
// expectations, then randomized traffic against an occupancy-based model.
module tb_dmux_1to4_reg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out1, out2, out3, out4;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [CNT_W-1:0] xfer_cnt;

   dmux_1to4_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out4      (out4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   logic [WIDTH-1:0] outs [4];
   assign outs[0] = out1;
   assign outs[1] = out2;
   assign outs[2] = out3;
   assign outs[3] = out4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: per-destination occupancy (capacity 1), last word
   // delivered into each destination, and accepted-word count modulo 2^CNT_W.
   int               occ   [4];
   logic [WIDTH-1:0] mword [4];
   int               mcnt;
   int               m_sel;
   bit               m_took [4];
   bit               m_acc;

   function automatic bit model_ready(input int s, input logic [3:0] ordy);
      int room_after_take;
      room_after_take = 1 - occ[s] + ((occ[s] > 0 && ordy[s]) ? 1 : 0);
      return room_after_take >= 1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            occ[i]   = 0;
            mword[i] = '0;
         end
         mcnt = 0;
      end else begin
         m_sel = int'(in_sel);
         m_acc = in_valid && model_ready(m_sel, out_ready);
         for (int i = 0; i < 4; i++) begin
            m_took[i] = occ[i] > 0 && out_ready[i];
            if (m_took[i]) occ[i] = occ[i] - 1;
         end
         if (m_acc) begin
            occ[m_sel]   = occ[m_sel] + 1;
            mword[m_sel] = in_data;
            mcnt         = (mcnt + 1) % (1 << CNT_W);
         end
      end
   end

   // Compare every registered output against the model once per cycle.
   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("model out_valid[%0d]", i), 32'(out_valid[i]), 32'(occ[i] != 0));
            chk($sformatf("model out%0d", i + 1), 32'(outs[i]), 32'(mword[i]));
         end
         chk("model xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
      end
   end

   // One clock of stimulus; in_ready is sampled mid-cycle and checked against the model.
   task automatic cycle(input logic rstn, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] ordy,
                        output logic rdy);
      @(negedge clk);
      rst_n     = rstn;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = ordy;
      #1;
      rdy = in_ready;
      if (check_en) chk("model in_ready", 32'(rdy), 32'(model_ready(int'(s), ordy)));
      @(posedge clk);
      #1;
   endtask

   task automatic check_ready_all(input string tag);
      for (int s = 0; s < 4; s++) begin
         in_valid  = 1'b0;
         in_sel    = 2'(s);
         out_ready = 4'b0000;
         #1;
         chk($sformatf("%s in_ready sel%0d", tag, s), 32'(in_ready), 32'd1);
      end
   endtask

   logic rdy;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_data = '0; out_ready = 4'b0000;

      cycle(1'b0, 1'b0, 2'b00, 16'h0000, 4'b0000, rdy);
      cycle(1'b0, 1'b0, 2'b00, 16'h0000, 4'b0000, rdy);
      check_en = 1'b1;
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset xfer_cnt", 32'(xfer_cnt), 32'h0);
      chk("reset out1", 32'(out1), 32'h0);
      chk("reset out4", 32'(out4), 32'h0);
      check_ready_all("reset");

      // First word to out3.
      cycle(1'b1, 1'b1, 2'b10, 16'h1234, 4'b0000, rdy);
      chk("first out3", 32'(out3), 32'h1234);
      chk("first out_valid", 32'(out_valid), 32'b0100);
      chk("first xfer_cnt", 32'(xfer_cnt), 32'd1);
      chk("first out1", 32'(out1), 32'h0);
      chk("first out2", 32'(out2), 32'h0);
      chk("first out4", 32'(out4), 32'h0);
      cycle(1'b1, 1'b0, 2'b00, 16'h0000, 4'b0100, rdy);
      chk("drain out_valid", 32'(out_valid), 32'h0);
      chk("drain keeps out3", 32'(out3), 32'h1234);

      // Back-pressure, then same-edge drain and refill.
      cycle(1'b1, 1'b1, 2'b00, 16'hAAAA, 4'b0000, rdy);
      cycle(1'b1, 1'b1, 2'b00, 16'hBBBB, 4'b0000, rdy);
      chk("bp in_ready", 32'(rdy), 32'd0);
      chk("bp out1 held", 32'(out1), 32'hAAAA);
      chk("bp xfer_cnt", 32'(xfer_cnt), 32'd2);
      cycle(1'b1, 1'b1, 2'b00, 16'hBBBB, 4'b0001, rdy);
      chk("refill in_ready", 32'(rdy), 32'd1);
      chk("refill out1", 32'(out1), 32'hBBBB);
      chk("refill out_valid", 32'(out_valid), 32'b0001);
      chk("refill xfer_cnt", 32'(xfer_cnt), 32'd3);
      cycle(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, rdy);

      // Streaming to all four destinations, consumers always ready.
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 1'b1, 2'((k - 1) % 4), 16'(k), 4'b1111, rdy);
         chk($sformatf("stream in_ready %0d", k), 32'(rdy), 32'd1);
         chk($sformatf("stream data %0d", k), 32'(outs[(k - 1) % 4]), 32'(k));
      end
      chk("stream xfer_cnt", 32'(xfer_cnt), 32'd11);
      cycle(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, rdy);

      // A blocked out4 does not stall traffic to out2.
      cycle(1'b1, 1'b1, 2'b11, 16'hDEAD, 4'b0000, rdy);
      cycle(1'b1, 1'b1, 2'b01, 16'h0F0F, 4'b0000, rdy);
      chk("indep in_ready", 32'(rdy), 32'd1);
      chk("indep out2", 32'(out2), 32'h0F0F);
      chk("indep out4", 32'(out4), 32'hDEAD);
      chk("indep out_valid", 32'(out_valid), 32'b1010);
      chk("indep xfer_cnt", 32'(xfer_cnt), 32'd13);
      cycle(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, rdy);

      // Counter wrap at 2^CNT_W.
      cycle(1'b1, 1'b1, 2'b00, 16'h0101, 4'b1111, rdy);
      cycle(1'b1, 1'b1, 2'b00, 16'h0202, 4'b1111, rdy);
      chk("wrap pre", 32'(xfer_cnt), 32'd15);
      cycle(1'b1, 1'b1, 2'b00, 16'h0303, 4'b1111, rdy);
      chk("wrap to zero", 32'(xfer_cnt), 32'd0);
      cycle(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, rdy);

      // Reset while all four slots hold words.
      for (int s = 0; s < 4; s++) cycle(1'b1, 1'b1, 2'(s), 16'hC000 + 16'(s), 4'b0000, rdy);
      chk("midrst pre out_valid", 32'(out_valid), 32'b1111);
      cycle(1'b0, 1'b1, 2'b00, 16'h5555, 4'b0000, rdy);
      chk("midrst out_valid", 32'(out_valid), 32'h0);
      chk("midrst out1", 32'(out1), 32'h0);
      chk("midrst out2", 32'(out2), 32'h0);
      chk("midrst out3", 32'(out3), 32'h0);
      chk("midrst out4", 32'(out4), 32'h0);
      chk("midrst xfer_cnt", 32'(xfer_cnt), 32'h0);
      check_ready_all("midrst");
      cycle(1'b1, 1'b0, 2'b00, 16'h0000, 4'b0000, rdy);
      chk("midrst word dropped", 32'(out1), 32'h0);
      chk("midrst still empty", 32'(out_valid), 32'h0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom % 64) != 0, ($urandom % 4) != 0, 2'($urandom % 4),
               16'($urandom), 4'($urandom), rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmux_1to4_reg.md
# dmux_1to4_reg

Registered 1-to-4 demultiplexer that steers one 16-bit input word to one of four destinations, selected by a 2-bit select. It is the distribution counterpart of the 4:1 operand mux: it dispatches a single producer's result, such as a write-back or forwarding value, to one of four consumers. Each destination has a one-entry holding register and a valid/ready handshake, so a stalled consumer back-pressures only words addressed to it.

## Interface
Parameters:
- WIDTH, 16, data width of the input and every output
- CNT_W, 16, width of the accepted-word counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_data  input  WIDTH  word to dispatch
- in_sel  input  2  destination index: 00→out1, 01→out2, 10→out3, 11→out4
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts the word this cycle
- out1, out2, out3, out4  output  WIDTH  held data per destination
- out_valid  output  4  bit i set: out(i+1) holds an undelivered word
- out_ready  input  4  bit i set: consumer i takes its word this cycle
- xfer_cnt  output  CNT_W  count of accepted input words

## Operation
- One holding slot per destination, each with a data register and a full flag. out_valid[i] = full[i]. out(i+1) = slot data register.
- in_ready = ~full[in_sel] | out_ready[in_sel].
  - Combinational from in_sel, full, and out_ready.
  - Independent of in_valid.
- Accept = in_valid & in_ready. On accept, slot[in_sel].data <= in_data, slot[in_sel].full <= 1.
- Drain of slot i = full[i] & out_ready[i].
  - If not refilled in the same cycle: full[i] <= 0.
  - Data register keeps its last value; it is not cleared.
- Same-slot drain + fill in one cycle: the consumer takes the old word. The new word is loaded and full stays 1, so there is no bubble.
- Different slots fill and drain independently in the same cycle.
- Accepting into an already full slot only happens alongside that slot's drain. No word is ever overwritten undelivered.
- xfer_cnt increments by 1 per accept and wraps from 2^CNT_W−1 to 0.
- Words reaching one destination keep their input order.
- out_ready[i] while full[i]=0 is ignored.
- in_sel and in_data are ignored when in_valid=0.

## Timing
- Reset (rst_n=0 at a clk edge): all full flags, out_valid, out1..out4 and xfer_cnt go to 0. in_ready is then 1 for any in_sel.
- Reset during activity: pending words are discarded without delivery. An accept in the reset cycle is ignored.
- Latency: word accepted at edge N appears with out_valid set after edge N. Earliest consumer take is at edge N+1.
- Throughput: one word per cycle. That includes back-to-back words to the same destination, provided its consumer holds out_ready=1.
- out_valid and out data are registered only. There is no combinational path from the input to the outputs.

## Structure
- Shared package dmux_pkg:
  - WIDTH default (16), NUM_DEST=4
  - sel_t 2-bit type
  - Select encodings SEL_OUT1..SEL_OUT4 (00..11), reused by the 4:1 mux select logic
- Sub-module dmux_slot:
  - One-entry buffer: data register, full flag, fill/drain logic.
  - Ports: clk, rst_n, fill, fill_data, take, data, full.
  - Instantiated four times. The top holds the select decode, in_ready generation and xfer_cnt.

## Test plan
- Reset, then in_valid=1:
  - in_sel=10, in_data=0x1234, out_ready=0000 → after 1 edge: out3=0x1234, out_valid=0100, xfer_cnt=1.
  - Other outputs stay 0x0000.
- Back-pressure:
  - Fill out1 with 0xAAAA, keep out_ready[0]=0, present 0xBBBB to 00 → in_ready=0, out1 stays 0xAAAA.
  - Then pulse out_ready[0]=1 → 0xAAAA is taken, 0xBBBB is accepted the same edge, out_valid[0] stays 1, out1=0xBBBB.
- Streaming: out_ready=1111, send 0x0001..0x0008 with sel cycling 00,01,10,11 on consecutive cycles → each word seen on its output one edge later, no stalls, xfer_cnt=8.
- Independence:
  - out4 blocked full (0xDEAD).
  - Send 0x0F0F to sel 01 → accepted immediately; out2=0x0F0F; out4 still 0xDEAD with out_valid[3]=1.
- Wrap: preload xfer_cnt to 0xFFFF via 65535 accepts (or CNT_W=4 with 15 accepts), one more accept → xfer_cnt=0.
- Mid-operation reset:
  - All four slots full, drive rst_n=0 for one edge → out_valid=0000, out1..out4=0, xfer_cnt=0, in_ready=1.
  - A word presented during reset is not captured.
